// File: rtl/addr_signed_serial_ft.sv
// +----------------------------------------------------------------------------+
// | addr_signed_serial_ft: digit-serial signed adder with mod-3 residue check. |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module addr_signed_serial_ft #(
    parameter int WIDTH     = 8,
    parameter int DIGIT     = 2,
    parameter int MAX_RETRY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             fault_inj,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             retried,
    output logic             err
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]          LAST_DIGIT = CW'(N - 1);
    localparam logic [2:0]             MAX_R      = 3'(MAX_RETRY);
    localparam logic signed [WIDTH+1:0] THREE     = {{WIDTH{1'b0}}, 2'b11};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        CHECK   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry;
    logic [CW-1:0]    dcnt;
    logic [2:0]       rcnt;

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT:0]   dsum;
    logic             carry_next;
    logic [WIDTH:0]   sum_next;

    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int k = 0; k < N; k++) begin
            if (int'(dcnt) == k) begin
                a_dig = a_r[k*DIGIT +: DIGIT];
                b_dig = b_r[k*DIGIT +: DIGIT];
            end
        end
        dsum       = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry};
        carry_next = dsum[DIGIT] ^ fault_inj;
        sum_next   = sum;
        for (int k = 0; k < N; k++) begin
            if (int'(dcnt) == k) begin
                sum_next[k*DIGIT +: DIGIT] = dsum[DIGIT-1:0];
            end
        end
        // Sign-extending both operands by one bit means the top bit can never overflow.
        if (dcnt == LAST_DIGIT) begin
            sum_next[WIDTH] = a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ carry_next;
        end
    end

    function automatic logic [1:0] mod3(input logic signed [WIDTH+1:0] x);
        logic signed [WIDTH+1:0] m;
        m = x % THREE;
        if (m[WIDTH+1]) begin
            m = m + THREE;
        end
        return m[1:0];
    endfunction

    logic [1:0] ra;
    logic [1:0] rb;
    logic [2:0] rsum;
    logic [1:0] r_res;
    logic [1:0] s_res;
    logic       residue_ok;

    always_comb begin
        ra         = mod3({{2{a_r[WIDTH-1]}}, a_r});
        rb         = mod3({{2{b_r[WIDTH-1]}}, b_r});
        rsum       = {1'b0, ra} + {1'b0, rb};
        r_res      = (rsum >= 3'd3) ? 2'(rsum - 3'd3) : rsum[1:0];
        s_res      = mod3({sum[WIDTH], sum});
        residue_ok = (r_res == s_res);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            err       <= 1'b0;
            retried   <= 1'b0;
            carry     <= 1'b0;
            dcnt      <= '0;
            rcnt      <= '0;
            a_r       <= '0;
            b_r       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= a;
                        b_r      <= b;
                        carry    <= 1'b0;
                        dcnt     <= '0;
                        rcnt     <= '0;
                        retried  <= 1'b0;
                        err      <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    sum   <= sum_next;
                    carry <= carry_next;
                    if (dcnt == LAST_DIGIT) begin
                        dcnt  <= '0;
                        state <= CHECK;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (residue_ok) begin
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (rcnt < MAX_R) begin
                        // Operands are still held in a_r/b_r, so just rerun the digits.
                        rcnt    <= rcnt + 3'd1;
                        retried <= 1'b1;
                        carry   <= 1'b0;
                        dcnt    <= '0;
                        state   <= COMPUTE;
                    end else begin
                        err       <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_addr_signed_serial_ft.sv
// Table-driven bench for addr_signed_serial_ft (WIDTH=8, DIGIT=2, MAX_RETRY=1).
`default_nettype none

module tb_addr_signed_serial_ft;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       fault_inj;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] sum;
    logic       retried;
    logic       err;

    int tests = 0;
    int fails = 0;

    addr_signed_serial_ft #(.WIDTH(8), .DIGIT(2), .MAX_RETRY(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .fault_inj(fault_inj),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .retried  (retried),
        .err      (err)
    );

    always #5 clk = ~clk;

    // fmode: 0 no fault, 1 fault in first COMPUTE cycle only, 2 fault held high throughout
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         fmode;
        logic [8:0] sum;
        logic       retried;
        logic       err;
        int         lat;
        int         stall;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_op(input int idx, input vec_t v);
        int   cyc;
        logic busy_bad;
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        check({tag, " in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = v.a;
        b        = v.b;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        a         = 8'($urandom);
        b         = 8'($urandom);
        fault_inj = (v.fmode != 0);
        cyc       = 0;
        busy_bad  = 1'b0;
        while (!out_valid && cyc < 40) begin
            if (in_ready) busy_bad = 1'b1;
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (v.fmode == 1) fault_inj = 1'b0;
        end
        fault_inj = 1'b0;
        check({tag, " latency"}, 32'(cyc), 32'(v.lat));
        check({tag, " in_ready_busy"}, 32'(busy_bad), 32'd0);
        check({tag, " sum"}, 32'(sum), 32'(v.sum));
        check({tag, " retried"}, 32'(retried), 32'(v.retried));
        check({tag, " err"}, 32'(err), 32'(v.err));
        for (int i = 0; i < v.stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, " stall_sum"}, 32'(sum), 32'(v.sum));
            check({tag, " stall_flags"}, {30'd0, retried, err}, {30'd0, v.retried, v.err});
            check({tag, " stall_hs"}, {30'd0, out_valid, in_ready}, 32'b10);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " back_to_idle"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        vecs[0]  = '{8'h7F, 8'h01, 0, 9'h080, 1'b0, 1'b0, 5, 0};
        vecs[1]  = '{8'h80, 8'h80, 0, 9'h100, 1'b0, 1'b0, 5, 0};
        vecs[2]  = '{8'hFF, 8'h01, 0, 9'h000, 1'b0, 1'b0, 5, 0};
        vecs[3]  = '{8'h01, 8'h01, 1, 9'h002, 1'b1, 1'b0, 10, 0};
        vecs[4]  = '{8'h01, 8'h01, 2, 9'h156, 1'b1, 1'b1, 10, 7};
        vecs[5]  = '{8'h00, 8'h00, 0, 9'h000, 1'b0, 1'b0, 5, 0};
        vecs[6]  = '{8'h7F, 8'h7F, 0, 9'h0FE, 1'b0, 1'b0, 5, 0};
        vecs[7]  = '{8'h80, 8'h7F, 0, 9'h1FF, 1'b0, 1'b0, 5, 0};
        vecs[8]  = '{8'h55, 8'hAA, 0, 9'h1FF, 1'b0, 1'b0, 5, 0};
        vecs[9]  = '{8'h7F, 8'h01, 1, 9'h080, 1'b1, 1'b0, 10, 0};
        vecs[10] = '{8'h12, 8'h34, 0, 9'h046, 1'b0, 1'b0, 5, 7};
        vecs[11] = '{8'hC0, 8'h30, 0, 9'h1F0, 1'b0, 1'b0, 5, 0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        fault_inj = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset outputs", {21'd0, out_valid, in_ready, sum}, {21'd0, 1'b0, 1'b1, 9'h000});
        check("reset flags", {30'd0, err, retried}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(i, vecs[i]);
        end

        // Reset mid-COMPUTE: partial result must be discarded.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 8'h7F;
        b        = 8'h7F;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst outputs", {21'd0, out_valid, in_ready, sum}, {21'd0, 1'b0, 1'b1, 9'h000});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst release", {30'd0, out_valid, in_ready}, 32'b01);
        run_op(100, vecs[11]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
